// File: rtl/xyzw_rec_packer.sv
// -----------------------------------------------------------------------------
// xyzw_rec_packer
// Purpose: accepts one {x, y, z, w} field set at a time, holds it for
// SETTLE_CYCLES cycles, packs it MSB-first into a REC_W-bit record and queues
// it in a 2-entry output buffer drained by a valid/ready handshake.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      field set on in_* is valid
//   in_ready   out  1      stage can accept a field set (IDLE)
//   in_x       in   1      field x (record MSB)
//   in_y       in   Y_W    field y
//   in_z       in   1      field z
//   in_w       in   W_W    field w (record LSBs)
//   out_valid  out  1      out_rec holds the head buffer entry
//   out_ready  in   1      consumer takes the head entry
//   out_rec    out  REC_W  packed record {x, y, z, w}
//   occupancy  out  2      buffer entries, 0..2
// -----------------------------------------------------------------------------
module xyzw_rec_packer #(
  parameter int SETTLE_CYCLES = 3,
  parameter int Y_W           = 4,
  parameter int W_W           = 2,
  localparam int REC_W        = 2 + Y_W + W_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_x,
  input  logic [Y_W-1:0]   in_y,
  input  logic             in_z,
  input  logic [W_W-1:0]   in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_rec,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PUSH   = 2'd2
  } state_t;

  // Counter reload value; a zero settle interval skips SETTLE entirely.
  localparam logic [3:0] C_CNT_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [REC_W-1:0]   r_hold;
  logic [REC_W-1:0]   r_mem [2];
  logic               r_head;
  logic               r_tail;
  logic [1:0]         r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [REC_W-1:0]   r_out_rec;

  state_t             w_state_next;
  logic [3:0]         w_cnt_next;
  logic               w_accept;
  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_count_next;
  logic               w_head_next;
  logic [REC_W-1:0]   w_head_rec;
  logic [REC_W-1:0]   w_out_rec_next;
  logic [REC_W-1:0]   w_packed_in;

  assign w_packed_in = {in_x, in_y, in_z, in_w};
  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_pop       = r_out_valid && out_ready;
  // A full buffer still takes the record when the head leaves on the same edge.
  assign w_push      = (r_state == PUSH) && ((r_count != 2'd2) || w_pop);

  // Next-state and settle-counter logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (SETTLE_CYCLES == 0) begin
            w_state_next = PUSH;
            w_cnt_next   = 4'd0;
          end else begin
            w_state_next = SETTLE;
            w_cnt_next   = C_CNT_LOAD;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = PUSH;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      PUSH: begin
        if (w_push) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = PUSH;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Buffer count/head bookkeeping and the value that will sit at the head.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
    w_head_next = w_pop ? ~r_head : r_head;
    // The record being written this edge lands at the new head when the
    // buffer would otherwise hold nothing ahead of it.
    if (w_push && (w_head_next == r_tail)) begin
      w_head_rec = r_hold;
    end else begin
      w_head_rec = r_mem[w_head_next];
    end
    // An empty buffer keeps showing the last popped value.
    if (w_count_next != 2'd0) begin
      w_out_rec_next = w_head_rec;
    end else begin
      w_out_rec_next = r_out_rec;
    end
  end

  // FSM state, settle counter and holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_hold     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_state_next == IDLE);
      if (w_accept) begin
        r_hold <= w_packed_in;
      end
    end
  end

  // Output buffer storage, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_rec   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= r_hold;
        r_tail        <= ~r_tail;
      end
      r_head      <= w_head_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != 2'd0);
      r_out_rec   <= w_out_rec_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_rec   = r_out_rec;
  assign occupancy = r_count;

endmodule

// File: tb/tb_xyzw_rec_packer.sv
// -----------------------------------------------------------------------------
// tb_xyzw_rec_packer
// Purpose: directed self-checking bench. Instance a_dut uses the default
// settle interval (3); instance b_dut uses a zero settle interval.
// -----------------------------------------------------------------------------
module tb_xyzw_rec_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: SETTLE_CYCLES = 3
  logic       a_rst_n, a_in_valid, a_in_ready, a_in_x, a_in_z;
  logic [3:0] a_in_y;
  logic [1:0] a_in_w;
  logic       a_out_valid, a_out_ready;
  logic [7:0] a_out_rec;
  logic [1:0] a_occ;

  // Instance B: SETTLE_CYCLES = 0
  logic       b_rst_n, b_in_valid, b_in_ready, b_in_x, b_in_z;
  logic [3:0] b_in_y;
  logic [1:0] b_in_w;
  logic       b_out_valid, b_out_ready;
  logic [7:0] b_out_rec;
  logic [1:0] b_occ;

  xyzw_rec_packer #(.SETTLE_CYCLES(3), .Y_W(4), .W_W(2)) a_dut (
    .clk(clk), .rst_n(a_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_x(a_in_x), .in_y(a_in_y), .in_z(a_in_z), .in_w(a_in_w),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_rec(a_out_rec), .occupancy(a_occ)
  );

  xyzw_rec_packer #(.SETTLE_CYCLES(0), .Y_W(4), .W_W(2)) b_dut (
    .clk(clk), .rst_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .in_z(b_in_z), .in_w(b_in_w),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_rec(b_out_rec), .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_fields(input logic [7:0] rec);
    a_in_x = rec[7];
    a_in_y = rec[6:3];
    a_in_z = rec[2];
    a_in_w = rec[1:0];
  endtask

  task automatic b_fields(input logic [7:0] rec);
    b_in_x = rec[7];
    b_in_y = rec[6:3];
    b_in_z = rec[2];
    b_in_w = rec[1:0];
  endtask

  // Wait (bounded) for in_ready on instance A, then present rec for one edge.
  task automatic a_send(input logic [7:0] rec);
    int waited;
    waited = 0;
    while (!a_in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("send_ready", a_in_ready, 1);
    a_fields(rec);
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  initial begin
    logic seen;
    int   sent, got, max_occ;

    // ---------------- Reset with in_valid held high ----------------
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b1; b_in_valid = 1'b1;
    a_fields(8'hD2); b_fields(8'hD2);
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_occ",       a_occ,       0);
    check("rst_out_rec",   a_out_rec,   8'h00);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();
    check("rst_no_accept", a_in_ready, 1);

    // ---------------- Basic pack: x=1 y=A z=0 w=10 -> D2 ----------------
    a_out_ready = 1'b1;
    a_in_x = 1'b1; a_in_y = 4'hA; a_in_z = 1'b0; a_in_w = 2'b10;
    a_in_valid = 1'b1;
    tick();                      // E0: accept
    a_in_valid = 1'b0;
    check("basic_in_ready_low", a_in_ready, 0);
    tick(); tick(); tick();      // E1..E3
    check("basic_not_early", a_out_valid, 0);
    tick();                      // E4: write
    check("basic_valid", a_out_valid, 1);
    check("basic_rec",   a_out_rec,   8'hD2);
    check("basic_occ1",  a_occ,       1);
    tick();                      // E5: pop
    check("basic_popped", a_out_valid, 0);
    check("basic_occ0",   a_occ,       0);

    // ---------------- Zero settle, back-to-back FF then 00 ----------------
    b_out_ready = 1'b1;
    b_fields(8'hFF);
    b_in_valid = 1'b1;
    tick();                      // E0: accept FF
    b_in_valid = 1'b0;
    check("zs_in_ready_low", b_in_ready, 0);
    check("zs_not_yet",      b_out_valid, 0);
    b_fields(8'h00);
    b_in_valid = 1'b1;
    tick();                      // E1: write FF, back to IDLE
    check("zs_ff_valid", b_out_valid, 1);
    check("zs_ff_rec",   b_out_rec,   8'hFF);
    check("zs_ready",    b_in_ready,  1);
    tick();                      // E2: accept 00, pop FF
    b_in_valid = 1'b0;
    check("zs_empty",    b_out_valid, 0);
    check("zs_busy",     b_in_ready,  0);
    tick();                      // E3: write 00
    check("zs_00_valid", b_out_valid, 1);
    check("zs_00_rec",   b_out_rec,   8'h00);
    tick();
    check("zs_drained",  b_occ, 0);

    // ---------------- Full buffer stall ----------------
    a_out_ready = 1'b0;
    a_send(8'h81);
    a_send(8'h42);
    a_send(8'h24);
    for (int i = 0; i < 5; i++) tick();
    check("stall_occ",      a_occ,       2);
    check("stall_head",     a_out_rec,   8'h81);
    check("stall_in_ready", a_in_ready,  0);
    check("stall_valid",    a_out_valid, 1);
    tick();
    check("stall_held", a_out_rec, 8'h81);
    a_out_ready = 1'b1;
    tick();                      // pop 81, write 24
    a_out_ready = 1'b0;
    check("stall_occ_same",  a_occ,      2);
    check("stall_head_42",   a_out_rec,  8'h42);
    check("stall_released",  a_in_ready, 1);
    a_out_ready = 1'b1;
    tick();
    check("stall_head_24", a_out_rec, 8'h24);
    check("stall_occ1",    a_occ,     1);
    tick();
    check("stall_empty",   a_out_valid, 0);

    // ---------------- Reset mid-settle ----------------
    a_out_ready = 1'b1;
    a_send(8'hD2);               // E0 accept
    tick();                      // E1 first SETTLE edge
    a_rst_n = 1'b0;
    tick();                      // E2 reset
    a_rst_n = 1'b1;
    check("rmid_in_ready", a_in_ready,  1);
    check("rmid_valid",    a_out_valid, 0);
    check("rmid_occ",      a_occ,       0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_out_valid) seen = 1'b1;
    end
    check("rmid_no_output", seen, 0);
    a_send(8'h3C);               // E0 accept
    tick(); tick(); tick();
    check("rmid_not_early", a_out_valid, 0);
    tick();
    check("rmid_3c_valid", a_out_valid, 1);
    check("rmid_3c_rec",   a_out_rec,   8'h3C);
    tick();

    // ---------------- Pointer wrap, 10 records ----------------
    sent = 0; got = 0; max_occ = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      a_out_ready = cyc[0];
      if (a_in_ready && sent < 10) begin
        a_fields(8'(sent + 1));
        a_in_valid = 1'b1;
        sent++;
      end else begin
        a_in_valid = 1'b0;
      end
      if (a_out_valid && a_out_ready) begin
        check("wrap_rec", a_out_rec, 32'(got + 1));
        got++;
      end
      if (int'(a_occ) > max_occ) max_occ = int'(a_occ);
      tick();
    end
    a_in_valid = 1'b0;
    check("wrap_count", got, 10);
    check("wrap_max_occ", (max_occ <= 2), 1);
    a_out_ready = 1'b1;
    tick(); tick();
    check("wrap_drained", a_occ, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xyzw_rec_packer.md
# xyzw_rec_packer

Upstream stage that assembles the packed test record `{x, y, z, w}` from individual field inputs and delivers it to the record-consuming stage. Each accepted field set is held for a programmable settle interval, packed MSB-first into one vector, and queued in a 2-entry output buffer. The buffer drains over a valid/ready handshake. The settle interval is the cycle-accurate counterpart of the continuous-assign and intra-assignment delays the downstream stage tolerates.

## Interface
- `SETTLE_CYCLES`, default 3: number of hold cycles between accept and push; legal range 0..15.
- `Y_W`, default 4: width of field `y`.
- `W_W`, default 2: width of field `w`.
- `REC_W`, derived: `2 + Y_W + W_W` (8 at defaults); not overridable.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: field set on `in_*` is valid.
- `in_ready` out 1: stage can accept a field set.
- `in_x` in 1: field `x`.
- `in_y` in `Y_W`: field `y`.
- `in_z` in 1: field `z`.
- `in_w` in `W_W`: field `w`.
- `out_valid` out 1: `out_rec` holds the head buffer entry.
- `out_ready` in 1: consumer takes the head entry.
- `out_rec` out `REC_W`: packed record `{x, y, z, w}`, where `x` is the MSB and `w` occupies the LSBs.
- `occupancy` out 2: number of buffer entries, 0..2.

## Operation
- FSM states: `IDLE`, `SETTLE`, `PUSH`.
- `in_ready` = (state == `IDLE`). It is registered-state-derived, with no combinational path from `in_valid`.
- Accept: in `IDLE` with `in_valid` high at an edge, the stage latches `in_x`, `in_y`, `in_z`, `in_w` into a holding register.
  - If `SETTLE_CYCLES` == 0: go to `PUSH`.
  - Otherwise: go to `SETTLE` with `cnt` = `SETTLE_CYCLES - 1`.
- `SETTLE`:
  - If `cnt` == 0: go to `PUSH`.
  - Otherwise: `cnt` decrements.
  - Inputs are ignored in this state.
- `PUSH`:
  - If the buffer is not full, or a pop occurs on the same edge: write the packed holding register at the tail and go to `IDLE`.
  - Otherwise: stay in `PUSH` and hold the record.
- Packing: `out_rec = {x, y[Y_W-1:0], z, w[W_W-1:0]}`. No truncation or extension is applied.
- Buffer: 2-entry FIFO with head/tail pointers (1 bit each, wrapping) and a 2-bit count.
  - Pop: `out_valid && out_ready` at an edge.
  - Push: `PUSH` state with a free slot.
  - Push and pop on the same edge, count 1 or 2: count is unchanged and pointers both advance.
  - Push and pop on the same edge, count 0: impossible, because `out_valid` = 0.
- `out_valid` = (count != 0). `out_rec` = entry at head. When the buffer is empty, `out_rec` holds the last popped value and carries no meaning.
- `occupancy` = count.
- No overflow is possible, because `PUSH` stalls. No underflow is possible, because a pop requires `out_valid`.

## Timing
- Reset (`rst_n` low at an edge), takes effect on that edge and wins over all other events:
  - state = `IDLE`, `cnt` = 0, pointers = 0, count = 0.
  - `in_ready` = 1, `out_valid` = 0, `occupancy` = 0, `out_rec` = 0, holding register = 0.
- Reset during `SETTLE` or `PUSH` discards the in-flight record. Buffered entries are discarded as well.
- Latency: with the buffer not full, accept at edge E0 writes at edge E0 + `SETTLE_CYCLES` + 1. `out_valid` rises after that edge.
  - `SETTLE_CYCLES` = 3: 4 edges.
  - `SETTLE_CYCLES` = 0: 1 edge.
- Throughput: one accept per `SETTLE_CYCLES` + 2 cycles at best. `in_ready` is low from the edge after an accept until the edge after the write.
- Backpressure: `out_ready` low with count 2 holds the FSM in `PUSH` indefinitely. The write occurs on the first edge with a pop, and `occupancy` stays 2 across that edge.
- `out_rec` and `out_valid` are stable while `out_valid` is high and `out_ready` is low.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 edges with `in_valid` = 1 → `in_ready` = 1, `out_valid` = 0, `occupancy` = 0, `out_rec` = 8'h00. No accept occurs during reset.
- **Basic pack:** with defaults and `out_ready` = 1, present x=1, y=4'hA, z=0, w=2'b10 with `in_valid` for one edge → `in_ready` drops the next cycle. `out_valid` rises exactly 4 edges after accept with `out_rec` = 8'hD2, and pops on the following edge. `occupancy` goes 0→1→0.
- **Zero settle:** with `SETTLE_CYCLES` = 0, back-to-back accepts of records 8'hFF then 8'h00 → each appears 1 edge after its accept. Accepts are spaced 2 cycles apart. Order is preserved.
- **Full buffer stall:** with `out_ready` = 0, accept three records 8'h81, 8'h42, 8'h24 → `occupancy` = 2 with head 8'h81, FSM held in `PUSH`, `in_ready` = 0. Raise `out_ready` for one edge → 8'h81 is popped, 8'h24 is written on the same edge, and `occupancy` stays 2. The head becomes 8'h42.
- **Reset mid-settle:** accept 8'hD2, then assert `rst_n` = 0 at the second `SETTLE` edge → no record is ever output. `in_ready` = 1 after release. A following accept of 8'h3C emerges after exactly 4 edges.
- **Pointer wrap:** stream 10 records (0x01..0x0A) with `out_ready` toggling every other cycle → all 10 emerge in order with no loss or duplication. `occupancy` never exceeds 2.
